// File: rtl/gf2_arith_pkg.sv
// Shared definitions for the GF(2)[x] divider: FSM state encodings and a
// constant clog2 used to size the counters.
package gf2_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One bit of GF(2) long division: shift the next dividend bit into the partial
// remainder and subtract (XOR) the divisor when the leading term is set.
module gf2_div_step #(
    parameter int unsigned N  = 521,
    parameter int unsigned PW = 10
) (
    input  logic [N-1:0]  r,
    input  logic          a_bit,
    input  logic [N-1:0]  d,
    input  logic [PW-1:0] deg,
    output logic [N-1:0]  r_next,
    output logic          q_bit
);

    logic [N:0] t;

    // Bit N of t^D is always zero (it is either the cancelled leading term when
    // deg==N or already zero), so only the low N bits are kept.
    always_comb begin
        t      = {r, a_bit};
        q_bit  = t[deg];
        r_next = {r[N-2:0], a_bit} ^ (d & {N{q_bit}});
    end

endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] long divider: finds deg(D) one bit per cycle, then
// consumes the dividend MSB first, producing quotient and remainder.
module gf2_poly_divider
    import gf2_arith_pkg::*;
#(
    parameter int unsigned N = 521
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N:0]     divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int unsigned CW = clog2(2*N+1);
    localparam int unsigned PW = clog2(N+1);

    logic [1:0]     state;
    logic [2*N-1:0] a_sh;
    logic [2*N-1:0] q_reg;
    logic [N:0]     d_reg;
    logic [N-1:0]   r_reg;
    logic [N-1:0]   r_next;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  deg;
    logic [CW-1:0]  cnt;
    logic           q_bit;

    gf2_div_step #(
        .N  (N),
        .PW (PW)
    ) u_step (
        .r      (r_reg),
        .a_bit  (a_sh[2*N-1]),
        .d      (d_reg[N-1:0]),
        .deg    (deg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    assign in_ready  = (state == ST_IDLE);
    assign quotient  = q_reg;
    assign remainder = r_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            a_sh        <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            ptr         <= '0;
            deg         <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh        <= dividend;
                        d_reg       <= divisor;
                        ptr         <= PW'(N);
                        r_reg       <= '0;
                        q_reg       <= '0;
                        div_by_zero <= 1'b0;
                        state       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (d_reg[ptr]) begin
                        deg   <= ptr;
                        cnt   <= CW'(2*N-1);
                        state <= ST_DIV;
                    end else if (ptr == '0) begin
                        div_by_zero <= 1'b1;
                        q_reg       <= '0;
                        r_reg       <= '0;
                        out_valid   <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        ptr <= ptr - PW'(1);
                    end
                end
                ST_DIV: begin
                    a_sh  <= a_sh << 1;
                    r_reg <= r_next;
                    q_reg <= {q_reg[2*N-2:0], q_bit};
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
